// File: rtl/exec_mem_slice.sv
// exec_mem_slice: RV32I control decode, ALU and 256-word data memory for the single-cycle core.
// Everything is combinational except the memory write port.
module exec_mem_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            func3,
    input  logic [6:0]            func7,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [9:0]            ld_w_addr,
    input  logic [DATA_WIDTH-1:0] ld_w_dat,
    input  logic                  ld_w_enb,
    output logic                  branch,
    output logic [2:0]            imm_src,
    output logic                  mem_read,
    output logic                  mem_2_reg,
    output logic [3:0]            alu_ctrl,
    output logic                  mem_write,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] wb_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0]            f3_op;
    logic [DATA_WIDTH-1:0] b;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                  unused;

    // func7[5] only distinguishes SRA from SRL here; SUB is resolved for OP alone
    assign f3_op = func3 == 3'b000 ? 4'b0000 :
                   func3 == 3'b001 ? 4'b0101 :
                   func3 == 3'b010 ? 4'b1000 :
                   func3 == 3'b011 ? 4'b1001 :
                   func3 == 3'b100 ? 4'b0100 :
                   func3 == 3'b101 ? (func7[5] ? 4'b0111 : 4'b0110) :
                   func3 == 3'b110 ? 4'b0011 : 4'b0010;

    always_comb begin
        branch    = 1'b0;
        imm_src   = 3'b000;
        mem_read  = 1'b0;
        mem_2_reg = 1'b0;
        alu_ctrl  = 4'b0000;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        if (!rst) begin
            case (opcode)
                OP_LOAD: begin
                    mem_read  = 1'b1;
                    mem_2_reg = 1'b1;
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_IMM: begin
                    alu_ctrl  = f3_op;
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_REG: begin
                    alu_ctrl  = (func3 == 3'b000 && func7[5]) ? 4'b0001 : f3_op;
                    reg_write = 1'b1;
                end
                OP_STORE: begin
                    imm_src   = 3'b001;
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    imm_src   = 3'b010;
                    branch    = 1'b1;
                    alu_ctrl  = 4'b0001;
                end
                default: ;
            endcase
        end
    end

    assign b     = alu_src ? imm : rs2;
    assign shamt = b[4:0];

    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = rs1 + b;
            4'b0001: alu_result = rs1 - b;
            4'b0010: alu_result = rs1 & b;
            4'b0011: alu_result = rs1 | b;
            4'b0100: alu_result = rs1 ^ b;
            4'b0101: alu_result = rs1 << shamt;
            4'b0110: alu_result = rs1 >> shamt;
            4'b0111: alu_result = $unsigned($signed(rs1) >>> shamt);
            4'b1000: alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1) < $signed(b)};
            4'b1001: alu_result = {{(DATA_WIDTH-1){1'b0}}, rs1 < b};
            default: alu_result = '0;
        endcase
    end

    assign zero      = alu_result == '0;
    assign mem_rdata = mem_read ? mem[alu_result[AW+1:2]] : '0;
    assign wb_data   = mem_2_reg ? mem_rdata : alu_result;
    assign unused    = ^{ld_w_addr[1:0], func7[6], func7[4:0]};

    // preload port wins; mem_write is already held low during reset
    always_ff @(posedge clk) begin
        if (ld_w_enb)
            mem[ld_w_addr[AW+1:2]] <= ld_w_dat;
        else if (mem_write)
            mem[alu_result[AW+1:2]] <= rs2;
    end
endmodule

// File: tb/tb_exec_mem_slice.sv
// tb_exec_mem_slice: directed table, hand sequences and randomized checks against an instruction-level model.
module tb_exec_mem_slice;
    logic        clk, rst;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, imm, ld_w_dat;
    logic [9:0]  ld_w_addr;
    logic        ld_w_enb;
    logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, zero;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result, mem_rdata, wb_data;

    exec_mem_slice dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .imm(imm), .ld_w_addr(ld_w_addr), .ld_w_dat(ld_w_dat),
        .ld_w_enb(ld_w_enb), .branch(branch), .imm_src(imm_src), .mem_read(mem_read),
        .mem_2_reg(mem_2_reg), .alu_ctrl(alu_ctrl), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .alu_result(alu_result), .zero(zero), .mem_rdata(mem_rdata),
        .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, OPR = 7'b0110011;
    localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, im;
        logic [12:0] ctl;
        logic [31:0] res, wb;
    } vec_t;

    int n_vec = 0, n_bad = 0;
    logic [31:0] ref_mem [256];
    logic [3:0]  f3_code [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    vec_t        tbl[$];
    logic [12:0] ctl_act;

    assign ctl_act = {branch, imm_src, mem_read, mem_2_reg, alu_ctrl, mem_write, alu_src, reg_write};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [12:0] model_ctl();
        logic [3:0] op;
        op = f3_code[func3];
        if (func3 == 3'd5 && func7[5]) op = 4'd7;
        if (rst) return '0;
        case (opcode)
            LOAD:    return 13'b0_000_1_1_0000_0_1_1;
            OPIMM:   return {1'b0, 3'b000, 2'b00, op, 3'b011};
            OPR:     return {1'b0, 3'b000, 2'b00, (func3 == 3'd0 && func7[5]) ? 4'd1 : op, 3'b001};
            STORE:   return 13'b0_001_0_0_0000_1_1_0;
            BRANCH:  return 13'b1_010_0_0_0001_0_0_0;
            default: return '0;
        endcase
    endfunction

    // Result from instruction semantics rather than through the ALU code
    function automatic logic [31:0] model_res();
        logic [31:0] a, b;
        logic        use_imm;
        use_imm = !rst && (opcode == LOAD || opcode == OPIMM || opcode == STORE);
        a = rs1;
        b = use_imm ? imm : rs2;
        if (rst) return a + b;
        if (opcode == BRANCH) return a - b;
        if (opcode != OPIMM && opcode != OPR) return a + b;
        case (func3)
            3'd0: return (opcode == OPR && func7[5]) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return func7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check_model(input string nm);
        logic [12:0] c;
        logic [31:0] r, rd;
        c  = model_ctl();
        r  = model_res();
        rd = c[8] ? ref_mem[r[9:2]] : 32'd0;
        chk({nm, ".ctl"}, {19'd0, ctl_act}, {19'd0, c});
        chk({nm, ".res"}, alu_result, r);
        chk({nm, ".zero"}, {31'd0, zero}, {31'd0, r == 32'd0});
        chk({nm, ".rdata"}, mem_rdata, rd);
        chk({nm, ".wb"}, wb_data, c[7] ? rd : r);
    endtask

    task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; imm = im; ld_w_enb = 1'b0;
        #1;
    endtask

    // Commit the model's write for this cycle alongside the DUT's clock edge
    task automatic step();
        logic [31:0] addr;
        addr = rs1 + imm;
        @(posedge clk);
        if (ld_w_enb) ref_mem[ld_w_addr[9:2]] = ld_w_dat;
        else if (!rst && opcode == STORE) ref_mem[addr[9:2]] = rs2;
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        ld_w_enb = 1'b1; ld_w_addr = a; ld_w_dat = d;
        step();
        ld_w_enb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld_w_enb = 1'b0; ld_w_addr = '0; ld_w_dat = '0;
        set(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("reset.ctl", {19'd0, ctl_act}, 32'd0);
        chk("reset.res", alu_result, 32'd0);
        chk("reset.zero", {31'd0, zero}, 32'd1);
        chk("reset.wb", wb_data, 32'd0);

        for (int i = 0; i < 256; i++) preload(10'(i * 4), $urandom);
        rst = 1'b0;
        preload(10'd0, 32'd1); preload(10'd4, 32'd2); preload(10'd8, 32'd3);
        preload(10'd12, 32'd4); preload(10'd20, 32'h11);

        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd8, 13'b0_000_1_1_0000_0_1_1, 32'd8, 32'd3});
        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd0, 13'b0_000_1_1_0000_0_1_1, 32'd0, 32'd1});
        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd4, 13'b0_000_1_1_0000_0_1_1, 32'd4, 32'd2});
        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd12, 13'b0_000_1_1_0000_0_1_1, 32'd12, 32'd4});
        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd13, 13'b0_000_1_1_0000_0_1_1, 32'd13, 32'd4});
        tbl.push_back('{LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'h400, 13'b0_000_1_1_0000_0_1_1, 32'h400, 32'd1});
        tbl.push_back('{OPR, 3'd0, 7'h20, 32'd5, 32'd5, 32'd0, 13'b0_000_0_0_0001_0_0_1, 32'd0, 32'd0});
        tbl.push_back('{OPR, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 13'b0_000_0_0_1000_0_0_1, 32'd1, 32'd1});
        tbl.push_back('{OPR, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 13'b0_000_0_0_1001_0_0_1, 32'd0, 32'd0});
        tbl.push_back('{7'h7F, 3'd0, 7'h00, 32'd3, 32'd4, 32'd0, 13'd0, 32'd7, 32'd7});
        tbl.push_back('{BRANCH, 3'd0, 7'h00, 32'd9, 32'd9, 32'd0, 13'b1_010_0_0_0001_0_0_0, 32'd0, 32'd0});
        tbl.push_back('{OPIMM, 3'd5, 7'h20, 32'h80000000, 32'd0, 32'd4, 13'b0_000_0_0_0111_0_1_1, 32'hF8000000, 32'hF8000000});
        tbl.push_back('{OPIMM, 3'd0, 7'h20, 32'd10, 32'd0, 32'd3, 13'b0_000_0_0_0000_0_1_1, 32'd13, 32'd13});
        foreach (tbl[i]) begin
            set(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].im);
            chk($sformatf("tbl%0d.ctl", i), {19'd0, ctl_act}, {19'd0, tbl[i].ctl});
            chk($sformatf("tbl%0d.res", i), alu_result, tbl[i].res);
            chk($sformatf("tbl%0d.zero", i), {31'd0, zero}, {31'd0, tbl[i].res == 32'd0});
            chk($sformatf("tbl%0d.rdata", i), mem_rdata, tbl[i].ctl[8] ? tbl[i].wb : 32'd0);
            chk($sformatf("tbl%0d.wb", i), wb_data, tbl[i].wb);
        end

        set(STORE, 3'd2, 7'd0, 32'd0, 32'hDEADBEEF, 32'd16);
        chk("store.ctl", {19'd0, ctl_act}, {19'd0, 13'b0_001_0_0_0000_1_1_0});
        chk("store.res", alu_result, 32'd16);
        step();
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd16);
        chk("store.readback", wb_data, 32'hDEADBEEF);

        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd4);
        ld_w_enb = 1'b1; ld_w_addr = 10'd4; ld_w_dat = 32'hAAAA5555; #1;
        chk("rdw.old", wb_data, 32'd2);
        step(); ld_w_enb = 1'b0; #1;
        chk("rdw.new", wb_data, 32'hAAAA5555);

        set(STORE, 3'd2, 7'd0, 32'd0, 32'h55, 32'd20);
        ld_w_enb = 1'b1; ld_w_addr = 10'd24; ld_w_dat = 32'h66;
        step();
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd20);
        chk("prio.store_blocked", wb_data, 32'h11);
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd24);
        chk("prio.preload", wb_data, 32'h66);

        rst = 1'b1;
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd5, 32'd8);
        chk("rst.ctl", {19'd0, ctl_act}, 32'd0);
        chk("rst.rdata", mem_rdata, 32'd0);
        chk("rst.res", alu_result, 32'd5);
        set(STORE, 3'd2, 7'd0, 32'd0, 32'h00000BAD, 32'd16);
        step();
        preload(10'd28, 32'h77);
        rst = 1'b0;
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd16);
        chk("rst.no_store", wb_data, 32'hDEADBEEF);
        set(LOAD, 3'd2, 7'd0, 32'd0, 32'd0, 32'd28);
        chk("rst.preload", wb_data, 32'h77);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [6];
            ops = '{LOAD, OPIMM, OPR, STORE, BRANCH, 7'($urandom)};
            rst = ($urandom_range(0, 9) == 0);
            set(ops[$urandom_range(0, 5)], 3'($urandom), {1'b0, 1'($urandom), 5'd0},
                $urandom, $urandom, $urandom);
            ld_w_enb = ($urandom_range(0, 3) == 0); ld_w_addr = 10'($urandom); ld_w_dat = $urandom;
            #1;
            check_model($sformatf("rnd%0d", i));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/exec_mem_slice.md
# exec_mem_slice

- Combinational RV32I decode and execute slice plus a 256-word data memory, for the single-cycle core.
- Decodes opcode/func3/func7 into datapath controls, evaluates the ALU on register and immediate operands, and performs the memory access.
- Writes back either the ALU result or the loaded word.
- Sits between register-file/sign-extend (decode) and register-file write-back; contains the `control`, `alu` and `bram32` functions.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- MEM_WORDS, 256, data memory depth (1 KiB, byte-addressed, word-aligned)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0]
- func3  in  3  instr[14:12]
- func7  in  7  instr[31:25]
- rs1  in  32  register operand A
- rs2  in  32  register operand B / store data
- imm  in  32  sign-extended immediate
- ld_w_addr  in  10  preload byte address
- ld_w_dat  in  32  preload data
- ld_w_enb  in  1  preload write enable
- branch  out  1  B-type instruction
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- mem_read  out  1  load
- mem_2_reg  out  1  write-back selects memory data
- alu_ctrl  out  4  ALU operation code
- mem_write  out  1  store
- alu_src  out  1  operand B = imm when 1, rs2 when 0
- reg_write  out  1  register write enable
- alu_result  out  32  ALU output
- zero  out  1  alu_result == 0
- mem_rdata  out  32  memory read data
- wb_data  out  32  mem_2_reg ? mem_rdata : alu_result

## Operation
alu_ctrl encoding:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
- 0101 SLL, 0110 SRL, 0111 SRA
- 1000 SLT (signed), 1001 SLTU
- Shifts use operand B[4:0]. SLT/SLTU produce 0 or 1.
- Undefined codes produce 0.

Control decode (all outputs 0 unless listed):
- 0000011 load (func3 010 LW; other func3 decode identically as word load): imm_src=000, mem_read=1, mem_2_reg=1, alu_src=1, reg_write=1, alu_ctrl=ADD.
- 0010011 OP-IMM: imm_src=000, alu_src=1, reg_write=1, alu_ctrl from func3. For func3 101, func7[5] selects SRA.
- 0110011 OP: reg_write=1, alu_ctrl from func3/func7[5]. func3 000 with func7[5]=1 is SUB.
- 0100011 store: imm_src=001, alu_src=1, mem_write=1, alu_ctrl=ADD.
- 1100011 branch: imm_src=010, branch=1, alu_ctrl=SUB.
- Any other opcode: all controls 0.
- func3 map: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.

Memory:
- Word index is byte address [9:2]; low two bits and upper bits are ignored.
- Read: mem_rdata = mem_read ? mem[alu_result[9:2]] : 0.
- Write port priority: ld_w_enb writes ld_w_dat at ld_w_addr[9:2]. Otherwise mem_write writes rs2 at alu_result[9:2].
- Write and read at the same index in the same cycle: read returns the old word until the clock edge.

Reset:
- While rst=1, all control outputs are forced to 0, so mem_rdata=0, reg_write=0 and no store occurs.
- While rst=1, alu_result still reflects the inputs, evaluated with the forced-0 controls (ADD of rs1 and rs2).
- Memory contents are not cleared by reset.
- ld_w_enb writes are honoured even during reset.

## Timing
- Decode, ALU, read path and wb_data are purely combinational; zero cycles of latency within a cycle.
- Memory write commits on the rising clk edge when enabled.
- A word written at edge N is readable from edge N onward.
- There is no internal state besides the memory array, and no handshakes.

## Test plan
- Preload: ld_w_enb at byte addrs 0,4,8,12 with 1,2,3,4. Then opcode=0000011, func3=010, rs1=0, imm=8 -> alu_result=8, mem_read=1, mem_2_reg=1, reg_write=1, alu_src=1, imm_src=000, mem_rdata=3, wb_data=3.
- Load sweep: imm=0,4,8,12 -> wb_data=1,2,3,4. Address bits: imm=13 -> 4 (low bits ignored); imm=0x400 -> 1 (wrap).
- R-type: func7=0100000, func3=000, rs1=5, rs2=5 -> alu_ctrl=SUB, alu_result=0, zero=1, wb_data=0. With rs1=0xFFFFFFFF, rs2=1 and SLT -> 1; SLTU -> 0.
- Store: opcode 0100011, rs1=0, imm=16, rs2=0xDEADBEEF, one edge. Then a load with imm=16 -> 0xDEADBEEF. Simultaneous ld_w_enb to a different address -> only the preload write occurs.
- Reset: rst=1 with load opcode -> all controls 0, mem_rdata=0. A store during rst does not change memory.
- Unknown opcode 1111111 -> all controls 0, wb_data=alu_result.
